// File: rtl/assembly_sequencer_pkg.sv
// rtl/assembly_sequencer_pkg.sv - shared encodings for the two-pass assembly sequencer
package assembly_sequencer_pkg;

    typedef enum logic [1:0] {
        ASM_IDLE            = 2'd0,
        PC_MAPPING          = 2'd1,
        INSTRUCTION_MAPPING = 2'd2
    } assembler_state_t;

    typedef enum logic [1:0] {
        SEQ_OK   = 2'd0,
        SEQ_ASM  = 2'd1,
        SEQ_LONG = 2'd2,
        SEQ_OVF  = 2'd3
    } seq_error_t;

    localparam logic [1:0] PH_IDLE  = 2'd0;
    localparam logic [1:0] PH_FETCH = 2'd1;
    localparam logic [1:0] PH_ISSUE = 2'd2;
    localparam logic [1:0] PH_GAP   = 2'd3;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;

    // Pass states are laid out FETCH, ISSUE, GAP so a streamer phase maps by offset.
    function automatic logic [3:0] stream_state(input logic [3:0] fetch_state, input logic [1:0] phase);
        return fetch_state + {2'b00, phase} - 4'd1;
    endfunction

endpackage

// File: rtl/assembly_sequencer_char_streamer.sv
// rtl/assembly_sequencer_char_streamer.sv - fetch/issue/gap character pacing with line and column counters
module assembly_sequencer_char_streamer
    import assembly_sequencer_pkg::*;
#(
    parameter int CHAR_PER_LINE   = 64,
    parameter int NUMBER_LINES    = 256,
    parameter int TEXT_DEPTH      = 4096,
    parameter int TEXT_RD_LATENCY = 2,
    parameter int CHAR_GAP        = 2,
    localparam int TW = $clog2(TEXT_DEPTH),
    localparam int LW = $clog2(NUMBER_LINES),
    localparam int CW = $clog2(CHAR_PER_LINE)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          start,
    input  logic          abort,
    input  logic [TW:0]   text_len,
    output logic [TW-1:0] text_addr,
    input  logic [7:0]    text_data,
    output logic          new_line,
    output logic          new_character,
    output logic [7:0]    incoming_character,
    output logic [LW-1:0] line_count,
    output logic [CW-1:0] char_count,
    output logic [1:0]    phase_next,
    output logic          pass_done,
    output logic          too_long
);

    logic [1:0]    phase_q;
    logic [7:0]    cnt;
    logic [TW-1:0] ptr;
    logic [7:0]    chr_q;
    logic [TW:0]   ptr_inc;
    logic          issuing, data_ordinary, held_ordinary;
    logic          fetch_done, gap_done, last;

    assign ptr_inc       = {1'b0, ptr} + (TW+1)'(1);
    assign last          = (ptr_inc == text_len);
    assign fetch_done    = (cnt == 8'(TEXT_RD_LATENCY - 1));
    assign gap_done      = (cnt == 8'(CHAR_GAP - 1));
    assign issuing       = (phase_q == PH_ISSUE);
    assign data_ordinary = (text_data != CH_LF) && (text_data != CH_CR);
    assign held_ordinary = (chr_q != CH_LF) && (chr_q != CH_CR);

    assign too_long           = issuing && data_ordinary && (char_count == CW'(CHAR_PER_LINE - 1));
    assign new_character      = issuing && data_ordinary && !too_long;
    assign new_line           = issuing && (text_data == CH_LF);
    assign incoming_character = issuing ? text_data : chr_q;
    assign pass_done          = (phase_q == PH_GAP) && gap_done && last;
    assign text_addr          = ptr;

    always_comb begin
        phase_next = phase_q;
        if (abort) begin
            phase_next = PH_IDLE;
        end else if (start) begin
            phase_next = PH_FETCH;
        end else begin
            case (phase_q)
                PH_FETCH: if (fetch_done) phase_next = PH_ISSUE;
                PH_ISSUE: phase_next = PH_GAP;
                PH_GAP:   if (gap_done) phase_next = last ? PH_IDLE : PH_FETCH;
                default:  phase_next = PH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            phase_q    <= PH_IDLE;
            cnt        <= '0;
            ptr        <= '0;
            chr_q      <= '0;
            line_count <= '0;
            char_count <= '0;
        end else begin
            phase_q <= phase_next;
            if (abort) begin
                cnt <= '0;
            end else if (start) begin
                cnt        <= '0;
                ptr        <= '0;
                line_count <= '0;
                char_count <= '0;
            end else begin
                case (phase_q)
                    PH_FETCH: cnt <= fetch_done ? 8'd0 : cnt + 8'd1;
                    PH_ISSUE: begin
                        chr_q <= text_data;
                        if (text_data == CH_LF) begin
                            line_count <= line_count + LW'(1);
                            char_count <= '0;
                        end
                    end
                    PH_GAP: begin
                        cnt <= gap_done ? 8'd0 : cnt + 8'd1;
                        if (gap_done) begin
                            if (held_ordinary) char_count <= char_count + CW'(1);
                            if (!last) ptr <= ptr + TW'(1);
                        end
                    end
                    default: cnt <= '0;
                endcase
            end
        end
    end

endmodule

// File: rtl/assembly_sequencer.sv
// rtl/assembly_sequencer.sv - two-pass assembler sequencer into imem; ASM_SEQ_CHECKSUM_EN adds a write checksum
module assembly_sequencer
    import assembly_sequencer_pkg::*;
#(
    parameter int CHAR_PER_LINE   = 64,
    parameter int NUMBER_LINES    = 256,
    parameter int TEXT_DEPTH      = 4096,
    parameter int TEXT_RD_LATENCY = 2,
    parameter int CHAR_GAP        = 2,
    localparam int TW = $clog2(TEXT_DEPTH),
    localparam int LW = $clog2(NUMBER_LINES),
    localparam int CW = $clog2(CHAR_PER_LINE)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          start,
    input  logic [TW:0]   text_len,
    output logic [TW-1:0] text_addr,
    input  logic [7:0]    text_data,
    output logic          new_line,
    output logic          new_character,
    output logic [7:0]    incoming_character,
    output logic [LW-1:0] line_count,
    output logic [CW-1:0] char_count,
    output logic [1:0]    assembler_state,
    input  logic [31:0]   asm_instruction,
    input  logic          asm_new_instruction,
    input  logic          asm_error,
    output logic          imem_we,
    output logic [LW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          busy,
    output logic          done,
    output logic [1:0]    error_code,
    output logic [LW-1:0] error_line,
    output logic [LW:0]   inst_count
`ifdef ASM_SEQ_CHECKSUM_EN
    ,
    output logic [31:0]   checksum
`endif
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] P1_FETCH = 4'd1;
    localparam logic [3:0] P1_ISSUE = 4'd2;
    localparam logic [3:0] P1_GAP   = 4'd3;
    localparam logic [3:0] P1_FLUSH = 4'd4;
    localparam logic [3:0] SWITCH   = 4'd5;
    localparam logic [3:0] P2_FETCH = 4'd6;
    localparam logic [3:0] P2_ISSUE = 4'd7;
    localparam logic [3:0] P2_GAP   = 4'd8;
    localparam logic [3:0] P2_FLUSH = 4'd9;
    localparam logic [3:0] DRAIN    = 4'd10;
    localparam logic [3:0] DONE     = 4'd11;
    localparam logic [3:0] ERROR    = 4'd12;

    logic [3:0] state, state_next;
    logic [1:0] drain_cnt;
    logic       in_p1, in_p2, err_window, cap_window;
    logic       asm_err, ovf_err, long_err, go_error, capture;
    logic       stream_start, s_new_line, s_pass_done, s_too_long;
    logic [1:0] s_phase_next;

    assign in_p1      = (state >= P1_FETCH) && (state <= P1_FLUSH);
    assign in_p2      = (state >= P2_FETCH) && (state <= P2_FLUSH);
    assign cap_window = in_p2 || (state == DRAIN);
    assign err_window = in_p1 || cap_window;

    assign asm_err  = err_window && asm_error;
    assign ovf_err  = cap_window && asm_new_instruction && !asm_err && (inst_count == (LW+1)'(NUMBER_LINES));
    assign long_err = s_too_long && !asm_err;
    assign go_error = asm_err || ovf_err || long_err;
    assign capture  = cap_window && asm_new_instruction && !go_error;

    assign stream_start = ((state == IDLE) && start && (text_len != '0)) || (state == SWITCH);

    assign new_line = s_new_line || (state == P1_FLUSH) || (state == P2_FLUSH);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE) || (state == ERROR);

    always_comb begin
        assembler_state = ASM_IDLE;
        if (in_p1)      assembler_state = PC_MAPPING;
        if (cap_window) assembler_state = INSTRUCTION_MAPPING;
    end

    assembly_sequencer_char_streamer #(
        .CHAR_PER_LINE   (CHAR_PER_LINE),
        .NUMBER_LINES    (NUMBER_LINES),
        .TEXT_DEPTH      (TEXT_DEPTH),
        .TEXT_RD_LATENCY (TEXT_RD_LATENCY),
        .CHAR_GAP        (CHAR_GAP)
    ) u_streamer (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .start              (stream_start),
        .abort              (go_error),
        .text_len           (text_len),
        .text_addr          (text_addr),
        .text_data          (text_data),
        .new_line           (s_new_line),
        .new_character      (new_character),
        .incoming_character (incoming_character),
        .line_count         (line_count),
        .char_count         (char_count),
        .phase_next         (s_phase_next),
        .pass_done          (s_pass_done),
        .too_long           (s_too_long)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = (text_len == '0) ? DONE : P1_FETCH;
            P1_FETCH, P1_ISSUE, P1_GAP:
                      state_next = s_pass_done ? P1_FLUSH : stream_state(P1_FETCH, s_phase_next);
            P1_FLUSH: state_next = SWITCH;
            SWITCH:   state_next = P2_FETCH;
            P2_FETCH, P2_ISSUE, P2_GAP:
                      state_next = s_pass_done ? P2_FLUSH : stream_state(P2_FETCH, s_phase_next);
            P2_FLUSH: state_next = DRAIN;
            DRAIN:    if (drain_cnt == 2'd3) state_next = DONE;
            default:  state_next = IDLE;
        endcase
        if (go_error) state_next = ERROR;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state      <= IDLE;
            drain_cnt  <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            error_code <= SEQ_OK;
            error_line <= '0;
            inst_count <= '0;
`ifdef ASM_SEQ_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            state     <= state_next;
            imem_we   <= 1'b0;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            if ((state == IDLE) && start) begin
                error_code <= SEQ_OK;
                error_line <= '0;
                inst_count <= '0;
`ifdef ASM_SEQ_CHECKSUM_EN
                checksum   <= '0;
`endif
            end
            if (go_error) begin
                error_line <= line_count;
                if (asm_err)      error_code <= SEQ_ASM;
                else if (ovf_err) error_code <= SEQ_OVF;
                else              error_code <= SEQ_LONG;
            end else if (capture) begin
                imem_we    <= 1'b1;
                imem_addr  <= inst_count[LW-1:0];
                imem_wdata <= asm_instruction;
                inst_count <= inst_count + (LW+1)'(1);
`ifdef ASM_SEQ_CHECKSUM_EN
                // Folded at capture time so the final word is included by the done pulse.
                checksum   <= {checksum[30:0], checksum[31]} ^ asm_instruction;
`endif
            end
        end
    end

endmodule
